// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
package mux_scan_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan controller signal bundle: start/mask request, mux select/feedback, valid/ready result.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic           start;
    logic [NCH-1:0] mask;
    logic           y;
    logic           s1;
    logic           s0;
    logic [NCH-1:0] data;
    logic           valid;
    logic           ready;
    logic           busy;

    modport master (
        input  start, mask, y, ready,
        output s1, s0, data, valid, busy
    );

    modport slave (
        output start, mask, y, ready,
        input  s1, s0, data, valid, busy
    );

endinterface

// File: rtl/mux_scan_ctrl_next.sv
// Combinational priority finder: lowest enabled channel strictly above cur (or the lowest
// enabled channel at all when cur_vld is low); last is set when no such channel exists.
module mux_scan_next
    import mux_scan_pkg::*;
(
    input  logic [NCH-1:0] mask,
    input  logic           cur_vld,
    input  sel_t           cur,
    output sel_t           nxt,
    output logic           last
);

    // Scan from the top down so the lowest qualifying channel is the one left standing.
    always_comb begin
        nxt  = '0;
        last = 1'b1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (!cur_vld || (i > int'(cur)))) begin
                nxt  = sel_t'(i);
                last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 4:1 mux selects over enabled channels, settles SETTLE+1 cycles per channel, samples y.
// Result held in DONE until valid&ready; all outputs registered, start ignored while busy.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_ctrl_if.master bus
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t         state_q, state_d;
    sel_t           sel_q, sel_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [NCH-1:0] data_q, data_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;

    sel_t           first_ch;
    logic           first_last;
    sel_t           step_ch;
    logic           step_last;

    // First channel comes from the live mask at acceptance, later steps from the latched one.
    mux_scan_next u_first (
        .mask    (bus.mask),
        .cur_vld (1'b0),
        .cur     ('0),
        .nxt     (first_ch),
        .last    (first_last)
    );

    mux_scan_next u_step (
        .mask    (mask_q),
        .cur_vld (1'b1),
        .cur     (sel_q),
        .nxt     (step_ch),
        .last    (step_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                sel_d = '0;
                if (bus.start) begin
                    data_d = '0;
                    busy_d = 1'b1;
                    if (!first_last) begin
                        mask_d  = bus.mask;
                        sel_d   = first_ch;
                        cnt_d   = SETTLE_C;
                        state_d = SCAN;
                    end else begin
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            SCAN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d[sel_q] = bus.y;
                    if (!step_last) begin
                        sel_d = step_ch;
                        cnt_d = SETTLE_C;
                    end else begin
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (bus.ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    sel_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                sel_d   = '0;
            end
        endcase
    end

    assign bus.s1    = sel_q[1];
    assign bus.s0    = sel_q[0];
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 4:1 mux closing the y loop.
module tb_mux_scan_ctrl;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ivec;

    mux_scan_ctrl_if bus ();

    mux_scan_ctrl #(.SETTLE(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.y = ivec[{bus.s1, bus.s0}];

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [3:0] iv;
        logic [3:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t tbl[7];

    // Issues a start, then counts edges after edge 0 until valid is seen; poke_at >= 0
    // drives a spurious start (mask 0001) at that count to exercise start-while-busy.
    task automatic scan(input logic [3:0] m, input int poke_at,
                        output int lat, output int sel_err, output int busy_err);
        int chs[$];
        for (int i = 0; i < 4; i++) if (m[i]) chs.push_back(i);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mask  = m;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mask  = 4'($urandom_range(15));
        @(negedge clk);
        lat = 0; sel_err = 0; busy_err = 0;
        while (!bus.valid && lat < 200) begin
            if (!bus.busy) busy_err++;
            if (lat / (S + 1) < chs.size()) begin
                if (int'({bus.s1, bus.s0}) != chs[lat / (S + 1)]) sel_err++;
            end else begin
                sel_err++;
            end
            bus.start = (lat == poke_at);
            if (lat == poke_at) bus.mask = 4'b0001;
            lat++;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic post_check(input string name, input logic [3:0] exp_data);
        @(negedge clk);
        check({name, "_valid_drop"}, bus.valid, 1'b0);
        check({name, "_idle_busy"}, bus.busy, 1'b0);
        check({name, "_idle_sel"}, {bus.s1, bus.s0}, 2'b00);
        check({name, "_data_hold"}, bus.data, exp_data);
    endtask

    initial begin
        int lat, se, be;
        logic [5:0] rec;

        bus.start = 1'b0;
        bus.mask  = 4'b0000;
        bus.ready = 1'b1;
        ivec      = 4'b0000;

        tbl[0] = '{4'b1111, 4'b0110, 4'b0110, 12};
        tbl[1] = '{4'b1010, 4'b1111, 4'b1010, 6};
        tbl[2] = '{4'b0000, 4'b1111, 4'b0000, 0};
        tbl[3] = '{4'b0100, 4'b0100, 4'b0100, 3};
        tbl[4] = '{4'b1001, 4'b0110, 4'b0000, 6};
        tbl[5] = '{4'b0111, 4'b1101, 4'b0101, 9};
        tbl[6] = '{4'b1000, 4'b1000, 4'b1000, 3};

        #12;
        check("rst_sel", {bus.s1, bus.s0}, 2'b00);
        check("rst_data", bus.data, 4'b0000);
        check("rst_valid", bus.valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            ivec = tbl[v].iv;
            scan(tbl[v].mask, -1, lat, se, be);
            check($sformatf("v%0d_latency", v), lat, tbl[v].exp_lat);
            check($sformatf("v%0d_data", v), bus.data, tbl[v].exp_data);
            check($sformatf("v%0d_sel_seq", v), se, 0);
            check($sformatf("v%0d_busy_scan", v), be, 0);
            check($sformatf("v%0d_busy_done", v), bus.busy, 1'b1);
            post_check($sformatf("v%0d", v), tbl[v].exp_data);
        end

        // Backpressure: valid and data must hold while ready is low.
        bus.ready = 1'b0;
        ivec = 4'b1111;
        scan(4'b1010, -1, lat, se, be);
        check("bp_latency", lat, 6);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_valid_hold%0d", c), bus.valid, 1'b1);
            check($sformatf("bp_data_hold%0d", c), bus.data, 4'b1010);
        end
        bus.ready = 1'b1;
        post_check("bp", 4'b1010);

        bus.ready = 1'b0;
        scan(4'b0000, -1, lat, se, be);
        check("bp0_latency", lat, 0);
        repeat (3) @(negedge clk);
        check("bp0_valid_hold", bus.valid, 1'b1);
        bus.ready = 1'b1;
        post_check("bp0", 4'b0000);

        // Start while busy must not disturb the running full scan.
        ivec = 4'b0110;
        scan(4'b1111, 4, lat, se, be);
        check("busy_start_latency", lat, 12);
        check("busy_start_data", bus.data, 4'b0110);
        check("busy_start_sel_seq", se, 0);
        post_check("busy_start", 4'b0110);

        // Abort a full scan with an asynchronous reset after edge 4.
        ivec = 4'b1111;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mask  = 4'b1111;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_sel", {bus.s1, bus.s0}, 2'b00);
        check("abort_data", bus.data, 4'b0000);
        check("abort_valid", bus.valid, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        @(negedge clk);
        check("abort_valid_in_rst", bus.valid, 1'b0);
        rst = 1'b0;
        ivec = 4'b0100;
        scan(4'b0100, -1, lat, se, be);
        check("abort_new_latency", lat, 3);
        check("abort_new_data", bus.data, 4'b0100);
        post_check("abort_new", 4'b0100);

        // Back-to-back empty scans with start held: one IDLE cycle between valid pulses.
        @(negedge clk);
        bus.start = 1'b1;
        bus.mask  = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rec[c] = bus.valid;
        end
        bus.start = 1'b0;
        check("valid_gap_pattern", rec, 6'b010101);
        @(negedge clk);
        check("valid_gap_idle", bus.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
